rr_gnt_ctrl: RTL and testbench

Registered round-robin grant controller that sits directly downstream of the combinational lowest-set-bit priority encoder. It uses a programmable priority pointer to turn a raw request vector into a held one-hot grant plus binary index. It presents the grant to a consumer over a valid/ready handshake and advances the pointer after each accepted grant. This gives fair, programmable-priority arbitration across WIDTH requesters.

---
 rtl/rr_pkg.sv | 28 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_gnt_ctrl.sv | 101 ++++++++++
 tb/tb_rr_gnt_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_W     = 1024;
    localparam int MAX_IDX_W = $clog2(MAX_W);

    function automatic int idx_w(input int width);
        return $clog2(width);
    endfunction

    // OR-tree encoder: each set bit contributes its position.
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(
        input logic [MAX_W-1:0] oh
    );
        logic [MAX_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (oh[i]) r = r | MAX_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational pointer-masked lowest-set-bit picker.
module rr_pick
    import rr_pkg::*;
#(
    parameter  int WIDTH = 512,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] p,
    output logic [WIDTH-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] mreq;
    logic [WIDTH-1:0] lo_m;
    logic [WIDTH-1:0] lo_r;

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i >= int'(p));
        end
    end

    assign mreq = req & mask;
    assign lo_m = mreq & (~mreq + WIDTH'(1));
    assign lo_r = req & (~req + WIDTH'(1));
    assign any  = |req;

    // Fall back to the unmasked vector when nothing sits at or above p.
    assign pick = (|mreq) ? lo_m : lo_r;
    assign idx  = IDX_W'(onehot2idx(MAX_W'(pick)));

endmodule

// File: rtl/rr_gnt_ctrl.sv
// Registered round-robin grant controller with programmable
// priority pointer and valid/ready grant handshake.
module rr_gnt_ctrl
    import rr_pkg::*;
#(
    parameter  int WIDTH = 512,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Req,
    output logic [WIDTH-1:0] Gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    input  logic             prio_load,
    input  logic [IDX_W-1:0] prio_ptr,
    output logic [IDX_W-1:0] ptr_o
);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pe;
    logic             accept;
    logic             any;
    logic [WIDTH-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] gnt_nx;
    logic [IDX_W-1:0] idx_nx;

    assign gnt_valid = (state == GRANT);
    assign accept    = gnt_valid & gnt_ready;
    assign ptr_o     = ptr;

    always_comb begin
        pe = ptr;
        if (prio_load)   pe = prio_ptr;
        else if (accept) pe = gnt_idx + IDX_W'(1);
    end

    rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req  (Req),
        .p    (pe),
        .pick (pick),
        .idx  (pick_idx),
        .any  (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= pe;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (any) state_nx = GRANT;
            GRANT: if (accept && !any) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A held grant is only replaced on accept; Req changes are ignored.
    always_comb begin
        gnt_nx = Gnt;
        idx_nx = gnt_idx;
        unique case (state)
            IDLE: begin
                gnt_nx = any ? pick : '0;
                idx_nx = any ? pick_idx : '0;
            end
            GRANT: begin
                if (accept) begin
                    gnt_nx = any ? pick : '0;
                    idx_nx = any ? pick_idx : '0;
                end
            end
            default: begin
                gnt_nx = '0;
                idx_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            Gnt     <= gnt_nx;
            gnt_idx <= idx_nx;
        end
    end

endmodule

// File: tb/tb_rr_gnt_ctrl.sv
// Directed vector bench for rr_gnt_ctrl at WIDTH=8 and WIDTH=512.
module tb_rr_gnt_ctrl;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       ld;
        logic [2:0] pp;
        logic       v;
        logic [2:0] idx;
        logic [2:0] ptr;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst8_n;
    logic         rst512_n;

    logic [7:0]   req8;
    logic [7:0]   gnt8;
    logic [2:0]   idx8;
    logic         v8;
    logic         rdy8;
    logic         ld8;
    logic [2:0]   pp8;
    logic [2:0]   ptr8;

    logic [511:0] req512;
    logic [511:0] gnt512;
    logic [8:0]   idx512;
    logic         v512;
    logic         rdy512;
    logic         ld512;
    logic [8:0]   pp512;
    logic [8:0]   ptr512;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    rr_gnt_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst8_n),
        .Req       (req8),
        .Gnt       (gnt8),
        .gnt_idx   (idx8),
        .gnt_valid (v8),
        .gnt_ready (rdy8),
        .prio_load (ld8),
        .prio_ptr  (pp8),
        .ptr_o     (ptr8)
    );

    rr_gnt_ctrl #(.WIDTH(512)) dut512 (
        .clk       (clk),
        .rst_n     (rst512_n),
        .Req       (req512),
        .Gnt       (gnt512),
        .gnt_idx   (idx512),
        .gnt_valid (v512),
        .gnt_ready (rdy512),
        .prio_load (ld512),
        .prio_ptr  (pp512),
        .ptr_o     (ptr512)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void add(input int r, input int rdy, input int ld,
                                input int pp, input int v, input int idx,
                                input int ptr);
        vec_t t;
        t.req = 8'(r);
        t.rdy = 1'(rdy);
        t.ld  = 1'(ld);
        t.pp  = 3'(pp);
        t.v   = 1'(v);
        t.idx = 3'(idx);
        t.ptr = 3'(ptr);
        tbl.push_back(t);
    endfunction

    initial begin
        logic [7:0] exp_gnt;

        // Rotation over 2,5,7 with full throughput.
        add(8'hA4, 1, 0, 0, 1, 2, 0);
        add(8'hA4, 1, 0, 0, 1, 5, 3);
        add(8'hA4, 1, 0, 0, 1, 7, 6);
        add(8'hA4, 1, 0, 0, 1, 2, 0);
        add(8'hA4, 1, 0, 0, 1, 5, 3);
        add(8'h00, 1, 0, 0, 0, 0, 6);
        // Priority load with wrap fallback.
        add(8'h03, 1, 1, 6, 1, 0, 6);
        add(8'h03, 1, 0, 0, 1, 1, 1);
        add(8'h03, 1, 0, 0, 1, 0, 2);
        add(8'h00, 1, 0, 0, 0, 0, 1);
        // Held grant under backpressure while Req changes.
        add(8'h08, 0, 0, 0, 1, 3, 1);
        add(8'h80, 0, 0, 0, 1, 3, 1);
        add(8'h80, 0, 0, 0, 1, 3, 1);
        add(8'h80, 0, 0, 0, 1, 3, 1);
        add(8'h80, 1, 0, 0, 1, 7, 4);
        // Sole requester 7 re-granted, pointer wraps.
        add(8'h80, 1, 0, 0, 1, 7, 0);
        add(8'h80, 1, 0, 0, 1, 7, 0);
        add(8'h80, 1, 0, 0, 1, 7, 0);
        // Accept together with prio_load.
        add(8'h26, 1, 0, 0, 1, 1, 0);
        add(8'h26, 1, 1, 5, 1, 5, 5);
        add(8'h00, 1, 0, 0, 0, 0, 6);
        // prio_load during a held grant only moves the pointer.
        add(8'h04, 0, 0, 0, 1, 2, 6);
        add(8'h04, 0, 1, 3, 1, 2, 3);
        add(8'h04, 1, 0, 0, 1, 2, 3);
        add(8'h00, 1, 0, 0, 0, 0, 3);

        rst8_n   = 1'b0;
        rst512_n = 1'b0;
        req8     = '0;
        rdy8     = 1'b0;
        ld8      = 1'b0;
        pp8      = '0;
        req512   = '0;
        rdy512   = 1'b0;
        ld512    = 1'b0;
        pp512    = '0;

        repeat (2) @(posedge clk);
        #1;
        rst8_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", int'(v8), 0);
        chk("rst_gnt", int'(gnt8), 0);
        chk("rst_idx", int'(idx8), 0);
        chk("rst_ptr", int'(ptr8), 0);

        foreach (tbl[k]) begin
            req8 = tbl[k].req;
            rdy8 = tbl[k].rdy;
            ld8  = tbl[k].ld;
            pp8  = tbl[k].pp;
            @(posedge clk);
            #1;
            exp_gnt = tbl[k].v ? (8'd1 << tbl[k].idx) : 8'd0;
            chk($sformatf("v%0d_valid", k), int'(v8), int'(tbl[k].v));
            chk($sformatf("v%0d_idx", k), int'(idx8), int'(tbl[k].idx));
            chk($sformatf("v%0d_gnt", k), int'(gnt8), int'(exp_gnt));
            chk($sformatf("v%0d_ptr", k), int'(ptr8), int'(tbl[k].ptr));
        end

        // Wide instance: grant 300, then async reset mid-grant.
        rst512_n = 1'b1;
        @(posedge clk);
        #1;
        req512      = '0;
        req512[300] = 1'b1;
        ld512       = 1'b1;
        pp512       = 9'd100;
        @(posedge clk);
        #1;
        ld512 = 1'b0;
        chk("w512_valid", int'(v512), 1);
        chk("w512_idx", int'(idx512), 300);
        chk("w512_gnt_bit", int'(gnt512[300]), 1);
        chk("w512_onehot", $countones(gnt512), 1);
        chk("w512_ptr", int'(ptr512), 100);
        #2;
        rst512_n = 1'b0;
        #1;
        chk("w512_arst_valid", int'(v512), 0);
        chk("w512_arst_gnt", int'(gnt512 != '0), 0);
        chk("w512_arst_idx", int'(idx512), 0);
        chk("w512_arst_ptr", int'(ptr512), 0);
        @(negedge clk);
        rst512_n    = 1'b1;
        req512      = '0;
        req512[0]   = 1'b1;
        rdy512      = 1'b1;
        @(posedge clk);
        #1;
        chk("w512_post_valid", int'(v512), 1);
        chk("w512_post_idx", int'(idx512), 0);
        chk("w512_post_gnt", int'(gnt512[0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
